// File: rtl/spi_log_packer.sv
// SPI flash read-log packer: queues {addr, len} records and serializes them to a byte stream.
// Define SPI_LOG_HEX_EN to emit each record as 11 ASCII bytes ("AAAAAA LL\r\n") instead of 4 raw bytes.
module spi_log_packer #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_25mhz,
    input  logic                     reset,
    input  logic                     log_strobe,
    input  logic [23:0]              log_addr,
    input  logic [7:0]               log_len,
    input  logic                     txd_ready,
    output logic [7:0]               txd,
    output logic                     txd_strobe,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               overflow_count,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
`ifdef SPI_LOG_HEX_EN
    localparam int NBYTES = 11;
`else
    localparam int NBYTES = 4;
`endif
    localparam logic [3:0]  LAST_IDX  = 4'(NBYTES - 1);
    localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_next;
    logic [3:0]      idx, idx_next;
    logic [31:0]     rec;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level_next;
    logic            full, push, pop, load, emit;
    logic [7:0]      cur_byte;

    // Full is judged on the registered level, so a pop in the same cycle cannot make room.
    assign full = (fifo_level == FULL_LVL);
    assign push = log_strobe && !full;
    assign pop  = load;

    always_comb begin
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + 1'b1;
            2'b01:   level_next = fifo_level - 1'b1;
            default: level_next = fifo_level;
        endcase
    end

    always_ff @(posedge clk_25mhz) begin
        if (push)
            mem[wr_ptr] <= {log_addr, log_len};
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            overflow_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_next;
            if (log_strobe && full && overflow_count != 8'hFF)
                overflow_count <= overflow_count + 1'b1;
        end
    end

`ifdef SPI_LOG_HEX_EN
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        case (idx)
            4'd0:    cur_byte = hex_ascii(rec[31:28]);
            4'd1:    cur_byte = hex_ascii(rec[27:24]);
            4'd2:    cur_byte = hex_ascii(rec[23:20]);
            4'd3:    cur_byte = hex_ascii(rec[19:16]);
            4'd4:    cur_byte = hex_ascii(rec[15:12]);
            4'd5:    cur_byte = hex_ascii(rec[11:8]);
            4'd6:    cur_byte = 8'h20;
            4'd7:    cur_byte = hex_ascii(rec[7:4]);
            4'd8:    cur_byte = hex_ascii(rec[3:0]);
            4'd9:    cur_byte = 8'h0D;
            default: cur_byte = 8'h0A;
        endcase
    end
`else
    always_comb begin
        case (idx)
            4'd0:    cur_byte = rec[31:24];
            4'd1:    cur_byte = rec[23:16];
            4'd2:    cur_byte = rec[15:8];
            default: cur_byte = rec[7:0];
        endcase
    end
`endif

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load       = 1'b0;
        emit       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    load       = 1'b1;
                    idx_next   = 4'd0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (txd_ready) begin
                    emit = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_next   = 4'd0;
                        state_next = IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            rec        <= '0;
            txd        <= '0;
            txd_strobe <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            txd_strobe <= emit;
            if (load)
                rec <= mem[rd_ptr];
            if (emit)
                txd <= cur_byte;
            // Registered from next-state values so it tracks the FSM and level it describes.
            busy <= (state_next != IDLE) || (level_next != '0);
        end
    end

endmodule

// File: tb/tb_spi_log_packer.sv
// Self-checking bench for spi_log_packer: directed latency/backpressure/overflow/reset steps plus random traffic.
module tb_spi_log_packer;

    localparam int DEPTH = 16;
`ifdef SPI_LOG_HEX_EN
    localparam int NB = 11;
`else
    localparam int NB = 4;
`endif

    logic        clk_25mhz = 1'b0;
    logic        reset;
    logic        log_strobe;
    logic [23:0] log_addr;
    logic [7:0]  log_len;
    logic        txd_ready;
    logic [7:0]  txd;
    logic        txd_strobe;
    logic [4:0]  fifo_level;
    logic [7:0]  overflow_count;
    logic        busy;

    spi_log_packer #(.DEPTH(DEPTH)) dut (
        .clk_25mhz      (clk_25mhz),
        .reset          (reset),
        .log_strobe     (log_strobe),
        .log_addr       (log_addr),
        .log_len        (log_len),
        .txd_ready      (txd_ready),
        .txd            (txd),
        .txd_strobe     (txd_strobe),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    always #20 clk_25mhz = ~clk_25mhz;

    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    int          nstrobes = 0;
    logic [7:0]  exp_q[$];
    int          strobe_cyc[$];
    logic [7:0]  mon_e;

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    // Byte monitor: every strobe must carry the next byte the model expects.
    always @(negedge clk_25mhz) begin
        if (txd_strobe === 1'b1) begin
            nstrobes++;
            strobe_cyc.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe got txd=%h expected no strobe", txd);
            end else begin
                mon_e = exp_q.pop_front();
                assert (txd === mon_e) else begin
                    fails++;
                    $error("FAIL txd_byte got %h expected %h", txd, mon_e);
                end
            end
        end
    end

    function automatic logic [7:0] asc(input int d);
        return (d < 10) ? 8'(48 + d) : 8'(55 + d);
    endfunction

    function automatic void push_exp(input logic [23:0] a, input logic [7:0] l);
`ifdef SPI_LOG_HEX_EN
        for (int k = 0; k < 6; k++)
            exp_q.push_back(asc(int'((a >> (20 - 4*k)) & 24'hF)));
        exp_q.push_back(8'h20);
        exp_q.push_back(asc(int'(l >> 4)));
        exp_q.push_back(asc(int'(l & 8'hF)));
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`else
        exp_q.push_back(a[23:16]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(l);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25mhz);
            #1;
        end
    endtask

    task automatic send(input logic [23:0] a, input logic [7:0] l);
        log_strobe = 1'b1;
        log_addr   = a;
        log_len    = l;
        tick(1);
        log_strobe = 1'b0;
    endtask

    task automatic drain(input int max);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < max) begin
            tick(1);
            n++;
        end
        check("drain_done", 32'(n < max), 32'd1);
    endtask

    initial begin
        #(40 * 60000);
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, s0, ov0;
        logic [23:0] a;
        logic [7:0]  l;
        reset = 1'b1; log_strobe = 1'b0; log_addr = '0; log_len = '0; txd_ready = 1'b0;
        tick(3);
        check("rst_txd", 32'(txd), 32'd0);
        check("rst_strobe", 32'(txd_strobe), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(2);

        // Single records: latency, throughput, busy release
        txd_ready = 1'b1;
        strobe_cyc.delete();
        c0 = cyc;
        push_exp(24'h123456, 8'h20);
        send(24'h123456, 8'h20);
        drain(60);
        check("single_count", 32'(strobe_cyc.size()), 32'(NB));
        check("single_first_cyc", 32'(strobe_cyc[0] - c0), 32'd3);
        check("single_last_cyc", 32'(strobe_cyc[NB-1] - c0), 32'(3 + NB - 1));
        tick(2);
        check("single_busy", 32'(busy), 32'd0);
        check("single_level", 32'(fifo_level), 32'd0);

        strobe_cyc.delete();
        c0 = cyc;
        push_exp(24'h00ABCD, 8'h0F);
        send(24'h00ABCD, 8'h0F);
        drain(60);
        check("rec2_count", 32'(strobe_cyc.size()), 32'(NB));
        check("rec2_first_cyc", 32'(strobe_cyc[0] - c0), 32'd3);

        // Backpressure after the second byte
        tick(2);
        strobe_cyc.delete();
        c0 = cyc;
        push_exp(24'hA5C3E1, 8'h7B);
        send(24'hA5C3E1, 8'h7B);
        tick(3);
        txd_ready = 1'b0;
        tick(10);
        txd_ready = 1'b1;
        drain(60);
        check("bp_count", 32'(strobe_cyc.size()), 32'(NB));
        check("bp_second_cyc", 32'(strobe_cyc[1] - c0), 32'd4);
        check("bp_third_cyc", 32'(strobe_cyc[2] - c0), 32'd15);

        // Overflow: one record stalled in the serializer, then DEPTH+3 back-to-back
        tick(2);
        txd_ready = 1'b0;
        a = 24'($urandom); l = 8'($urandom);
        push_exp(a, l);
        send(a, l);
        tick(3);
        check("ovf_pre_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < DEPTH + 3; i++) begin
            a = 24'($urandom); l = 8'($urandom);
            if (i < DEPTH) push_exp(a, l);
            log_strobe = 1'b1; log_addr = a; log_len = l;
            tick(1);
        end
        log_strobe = 1'b0;
        tick(1);
        check("ovf_level", 32'(fifo_level), 32'(DEPTH));
        check("ovf_count", 32'(overflow_count), 32'd3);
        check("ovf_busy", 32'(busy), 32'd1);
        txd_ready = 1'b1;
        drain((DEPTH + 1) * (NB + 2) + 50);
        check("ovf_count_hold", 32'(overflow_count), 32'd3);
        check("ovf_level_empty", 32'(fifo_level), 32'd0);

        // Saturation of the drop counter, then cleared only by reset
        txd_ready = 1'b0;
        log_strobe = 1'b1;
        for (int i = 0; i < 300 + DEPTH + 1; i++) begin
            log_addr = 24'($urandom); log_len = 8'($urandom);
            tick(1);
        end
        log_strobe = 1'b0;
        tick(1);
        check("sat_count", 32'(overflow_count), 32'd255);
        exp_q.delete();
        reset = 1'b1;
        #5;
        check("sat_rst_overflow", 32'(overflow_count), 32'd0);
        check("sat_rst_level", 32'(fifo_level), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Reset mid-record with 3 records queued
        for (int i = 0; i < 4; i++) begin
            a = 24'($urandom); l = 8'($urandom);
            push_exp(a, l);
            send(a, l);
        end
        tick(2);
        check("mid_level", 32'(fifo_level), 32'd3);
        s0 = nstrobes;
        txd_ready = 1'b1;
        tick(2);
        txd_ready = 1'b0;
        tick(1);
        check("mid_two_bytes", 32'(nstrobes - s0), 32'd2);
        #5;
        reset = 1'b1;
        #1;
        check("mid_rst_txd", 32'(txd), 32'd0);
        check("mid_rst_strobe", 32'(txd_strobe), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        txd_ready = 1'b1;
        tick(1);
        reset = 1'b0;
        s0 = nstrobes;
        tick(30);
        check("mid_no_strobes", 32'(nstrobes - s0), 32'd0);
        push_exp(24'hFEDCBA, 8'h98);
        send(24'hFEDCBA, 8'h98);
        drain(60);
        check("mid_new_record", 32'(nstrobes - s0), 32'(NB));

        // Random sparse traffic with random backpressure
        ov0 = int'(overflow_count);
        for (int i = 0; i < 600; i++) begin
            txd_ready = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) begin
                a = 24'($urandom); l = 8'($urandom);
                push_exp(a, l);
                log_strobe = 1'b1; log_addr = a; log_len = l;
            end else begin
                log_strobe = 1'b0;
            end
            tick(1);
        end
        log_strobe = 1'b0;
        txd_ready = 1'b1;
        drain(DEPTH * (NB + 2) + 100);
        check("rand_no_drops", 32'(overflow_count), 32'(ov0));
        check("rand_level_empty", 32'(fifo_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
